// File: rtl/io_pkg.sv
// io_pkg: shared types and constants for the memory-mapped I/O port.
//   IO_DATA_W    default data word width
//   out_state_e  output-side handshake FSM state
//   IO_IN_ADDR   data-memory address decoded into in_sig (CPU read)
//   IO_OUT_ADDR  data-memory address decoded into out_sig (CPU write)
package io_pkg;

    localparam int unsigned IO_DATA_W = 16;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_BUSY = 1'b1
    } out_state_e;

    localparam logic [15:0] IO_IN_ADDR  = 16'h0400;
    localparam logic [15:0] IO_OUT_ADDR = 16'h0402;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: small synchronous FIFO with a combinational head word.
//   clk, reset        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data   write a word (ignored while full)
//   pop               drop the head word (ignored while empty)
//   head              word at the read pointer, valid while !empty
//   full, empty       derived from the registered occupancy count
// DEPTH must be a power of two so the pointers wrap naturally.
module io_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_en;
    logic              pop_en;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Storage needs no reset: reset only has to clear the occupancy state.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + 1'b1;
            end else if (pop_en && !push_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_io_port.sv
// mem_io_port: memory-mapped I/O endpoint driven by the data-memory decoder strobes.
//   clk, reset                  clock, asynchronous active-high reset
//   in_sig, rd_data             CPU read of the input port; rd_data is the FIFO head or 0
//   out_sig, wr_data            CPU write of the output port
//   stall                       hold the CPU, the access is retried next cycle
//   ext_in_data/valid/ready     producer side, buffered in an IN_DEPTH-word FIFO
//   ext_out_data/valid/ready    consumer side, one held word
//   io_err                      one-cycle pulse when a stalled access is aborted
// Optional feature: define IO_TIMEOUT_EN to abort any access stalled for TIMEOUT_CYC cycles.
// Without it io_err is tied low and a stall may last indefinitely.
module mem_io_port
    import io_pkg::*;
#(
    parameter int unsigned DATA_W      = IO_DATA_W,
    parameter int unsigned IN_DEPTH    = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_sig,
    input  logic              out_sig,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic              io_err
);

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_push;
    logic              fifo_pop;

    logic              read_stall;
    logic              write_stall;
    logic              raw_stall;
    logic              abort;
    logic              wr_accept;

    out_state_e        out_state_q;
    logic [DATA_W-1:0] out_data_q;

    // ---------------- input side ----------------
    // Readiness comes from the registered count only, so a full FIFO refuses
    // a push even when the CPU pops in the same cycle.
    assign ext_in_ready = ~fifo_full;
    assign fifo_push    = ext_in_valid & ~fifo_full;

    // A simultaneous write wins: the read stalls and nothing is popped.
    assign fifo_pop = in_sig & ~out_sig & ~fifo_empty;
    assign rd_data  = fifo_pop ? fifo_head : '0;

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (ext_in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- stall / abort ----------------
    assign read_stall  = in_sig & (out_sig | fifo_empty);
    assign write_stall = out_sig & (out_state_q == OUT_BUSY) & ~ext_out_ready;
    assign raw_stall   = read_stall | write_stall;
    assign stall       = raw_stall & ~abort;
    // An aborted write is dropped; the pending outgoing word is untouched.
    assign wr_accept   = out_sig & ~write_stall & ~abort;

`ifdef IO_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;

    assign abort  = raw_stall & (to_cnt_q == TO_W'(TIMEOUT_CYC));
    assign io_err = abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (!raw_stall || abort) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYC;
    assign abort          = 1'b0;
    assign io_err         = 1'b0;
`endif

    // ---------------- output side ----------------
    assign ext_out_valid = (out_state_q == OUT_BUSY);
    assign ext_out_data  = out_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_state_q <= OUT_IDLE;
            out_data_q  <= '0;
        end else begin
            unique case (out_state_q)
                OUT_IDLE: begin
                    if (wr_accept) begin
                        out_data_q  <= wr_data;
                        out_state_q <= OUT_BUSY;
                    end
                end
                OUT_BUSY: begin
                    // Held word leaves on ready; a write in the same cycle refills it.
                    if (ext_out_ready) begin
                        if (wr_accept) begin
                            out_data_q <= wr_data;
                        end else begin
                            out_state_q <= OUT_IDLE;
                        end
                    end
                end
                default: out_state_q <= OUT_IDLE;
            endcase
        end
    end

endmodule
